// File: rtl/target_route_sequencer.sv
// target_route_sequencer
// Steps through a programmable route of up to 8 polar target locations
// (12-bit: [11:7] theta in 15-degree units, [6:0] r in inches) and presents
// one target at a time to the path planner. It advances on arrival after a
// settle dwell, and drops into FAULT if arrival does not happen in time.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data  table write; ignored while busy
//   route_len           waypoint count sampled on start (clamped to 8)
//   start               single-cycle pulse, begins route at entry 0
//   arrived             single-cycle pulse from navigation
//   abort               level, returns any busy state to IDLE
//   target_location     current target (held after settle/done/abort)
//   target_valid        high while waiting for arrival
//   index               table entry currently issued
//   busy                high in ISSUE, WAIT_ARRIVE, SETTLE
//   route_done          one-cycle pulse on entering DONE
//   timeout_fault       sticky until the next start or reset
//   dbg_state           current FSM state encoding
//
// Handshake: start, arrived and wr_en are sampled on the rising clock edge;
// each is acted upon at most once per cycle it is high, and only in the
// states listed above. abort wins over every other input.
module target_route_sequencer #(
  parameter logic [31:0] SETTLE_CYCLES    = 32'd27_000_000,
  parameter logic [31:0] TIMEOUT_CYCLES   = 32'd1_620_000_000,
  parameter logic [11:0] DEFAULT_LOCATION = {5'h06, 7'h18}
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [11:0] wr_data,
  input  logic [3:0]  route_len,
  input  logic        start,
  input  logic        arrived,
  input  logic        abort,
  output logic [11:0] target_location,
  output logic        target_valid,
  output logic [2:0]  index,
  output logic        busy,
  output logic        route_done,
  output logic        timeout_fault,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] loc_tab_q [8];
  logic [11:0] loc_tab_d [8];
  logic [11:0] target_q, target_d;
  logic        valid_q, valid_d;
  logic [2:0]  index_q, index_d;
  logic [3:0]  len_q, len_d;
  logic [31:0] timer_q, timer_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        busy_w;

  assign busy_w = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_SETTLE);

  always_comb begin
    state_d   = state_q;
    loc_tab_d = loc_tab_q;
    target_d  = target_q;
    valid_d   = valid_q;
    index_d   = index_q;
    len_d     = len_q;
    timer_d   = timer_q;
    done_d    = 1'b0;
    fault_d   = fault_q;

    if (wr_en && !busy_w) begin
      loc_tab_d[wr_addr] = wr_data;
    end

    case (state_q)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start && !abort) begin
          len_d   = (route_len > 4'd8) ? 4'd8 : route_len;
          index_d = 3'd0;
          fault_d = 1'b0;
          timer_d = 32'd0;
          if (route_len == 4'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // Table is read here, one cycle after start, so a write issued
        // alongside start is already visible.
        target_d = loc_tab_q[index_q];
        timer_d  = 32'd0;
        valid_d  = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (arrived) begin
          state_d = S_SETTLE;
          timer_d = 32'd0;
          valid_d = 1'b0;
        end else if (timer_q == TIMEOUT_CYCLES - 32'd1) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_SETTLE: begin
        if (timer_q == SETTLE_CYCLES - 32'd1) begin
          timer_d = 32'd0;
          if ({1'b0, index_q} == len_q - 4'd1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + 3'd1;
            state_d = S_ISSUE;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the state logic decided; the last target
    // stays on target_location so the planner sees a stable value.
    if (abort && busy_w) begin
      state_d = S_IDLE;
      index_d = 3'd0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      timer_d = 32'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < 8; i++) loc_tab_q[i] <= DEFAULT_LOCATION;
      target_q <= DEFAULT_LOCATION;
      valid_q  <= 1'b0;
      index_q  <= 3'd0;
      len_q    <= 4'd0;
      timer_q  <= 32'd0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      loc_tab_q <= loc_tab_d;
      target_q  <= target_d;
      valid_q   <= valid_d;
      index_q   <= index_d;
      len_q     <= len_d;
      timer_q   <= timer_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  assign target_location = target_q;
  assign target_valid    = valid_q;
  assign index           = index_q;
  assign busy            = busy_w;
  assign route_done      = done_q;
  assign timeout_fault   = fault_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_target_route_sequencer.sv
// Directed bench for target_route_sequencer with SETTLE=4, TIMEOUT=20.
module tb_target_route_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;
  logic [3:0]  route_len;
  logic        start;
  logic        arrived;
  logic        abort;
  logic [11:0] target_location;
  logic        target_valid;
  logic [2:0]  index;
  logic        busy;
  logic        route_done;
  logic        timeout_fault;
  logic [2:0]  dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [11:0] exp_q[$];
  logic [11:0] ent [8];

  target_route_sequencer #(
    .SETTLE_CYCLES(32'd4),
    .TIMEOUT_CYCLES(32'd20),
    .DEFAULT_LOCATION(12'h318)
  ) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .route_len(route_len), .start(start),
    .arrived(arrived), .abort(abort), .target_location(target_location),
    .target_valid(target_valid), .index(index), .busy(busy),
    .route_done(route_done), .timeout_fault(timeout_fault),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic wr(input logic [2:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!target_valid && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_start(input logic [3:0] len);
    route_len = len; start = 1'b1;
    step();
    start = 1'b0; wr_en = 1'b0;
  endtask

  // Runs a whole route; expected targets come from exp_q in order.
  task automatic run_route(input logic [3:0] len);
    int cyc, pulses, vhigh, n;
    logic [11:0] e;
    n = exp_q.size();
    pulse_start(len);
    wait_valid(cyc);
    check("start_to_valid", cyc + 1, 2);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check("target", target_location, e);
      check("index", index, i);
      arrived = 1'b1;
      step();
      arrived = 1'b0;
      if (i < n - 1) begin
        wait_valid(cyc);
        check("arrive_gap", cyc + 1, 6);
      end else begin
        pulses = 0; vhigh = 0;
        for (int k = 0; k < 12; k++) begin
          if (route_done) pulses++;
          if (target_valid) vhigh++;
          step();
        end
        check("done_pulses", pulses, 1);
        check("valid_after_done", vhigh, 0);
        check("busy_done", busy, 0);
        check("hold_target", target_location, e);
        check("index_done", index, i);
      end
    end
  endtask

  initial begin
    int cyc, cnt;
    reset = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 12'd0;
    route_len = 4'd0; start = 1'b0; arrived = 1'b0; abort = 1'b0;
    #2;
    check("rst_target", target_location, 12'h318);
    check("rst_valid", target_valid, 0);
    check("rst_index", index, 0);
    check("rst_busy", busy, 0);
    check("rst_done", route_done, 0);
    check("rst_fault", timeout_fault, 0);
    #21 reset = 1'b0;
    step();

    // default table, three waypoints
    repeat (3) exp_q.push_back(12'h318);
    run_route(4'd3);

    // programmed entries; entry2 written on the same cycle as start
    wr(3'd1, {5'h01, 7'h20});
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = {5'h0B, 7'h50};
    exp_q.push_back(12'h318); exp_q.push_back(12'h0A0); exp_q.push_back(12'h5D0);
    run_route(4'd3);

    // timeout
    pulse_start(4'd2);
    wait_valid(cyc);
    wait_idle(cyc);
    check("timeout_cycles", cyc, 20);
    check("fault_set", timeout_fault, 1);
    check("fault_busy", busy, 0);
    check("fault_valid", target_valid, 0);
    check("fault_target", target_location, 12'h318);
    step();
    check("fault_sticky", timeout_fault, 1);

    // restart clears fault; abort during SETTLE
    pulse_start(4'd3);
    check("fault_cleared", timeout_fault, 0);
    wait_valid(cyc);
    arrived = 1'b1; step(); arrived = 1'b0;
    check("settle_busy", busy, 1);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", target_valid, 0);
    check("abort_index", index, 0);
    check("abort_target", target_location, 12'h318);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (route_done || target_valid) cnt++;
      step();
    end
    check("abort_quiet", cnt, 0);

    // abort together with arrived
    pulse_start(4'd3);
    wait_valid(cyc);
    arrived = 1'b1; abort = 1'b1; step(); arrived = 1'b0; abort = 1'b0;
    check("abort_arr_busy", busy, 0);
    check("abort_arr_valid", target_valid, 0);
    check("abort_arr_index", index, 0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (route_done || target_valid || busy) cnt++;
      step();
    end
    check("abort_arr_quiet", cnt, 0);

    // zero-length route
    pulse_start(4'd0);
    check("len0_done", route_done, 1);
    check("len0_busy", busy, 0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (route_done || target_valid) cnt++;
    end
    check("len0_quiet", cnt, 0);

    // length 15 clamps to 8 targets
    for (int i = 0; i < 8; i++) begin
      ent[i] = 12'((i + 1) << 7) | 12'(i * 9 + 3);
      wr(3'(i), ent[i]);
      exp_q.push_back(ent[i]);
    end
    run_route(4'd15);

    // write while waiting for arrival is dropped
    pulse_start(4'd1);
    wait_valid(cyc);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 12'hFFF;
    step();
    wr_en = 1'b0;
    arrived = 1'b1; step(); arrived = 1'b0;
    wait_idle(cyc);
    exp_q.push_back(ent[0]);
    run_route(4'd1);

    // reset mid-route restores the defaults
    pulse_start(4'd3);
    wait_valid(cyc);
    arrived = 1'b1; step(); arrived = 1'b0;
    wait_valid(cyc);
    check("pre_reset_index", index, 1);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", target_valid, 0);
    check("mid_rst_index", index, 0);
    check("mid_rst_target", target_location, 12'h318);
    @(posedge clock);
    #3 reset = 1'b0;
    step();
    repeat (3) exp_q.push_back(12'h318);
    run_route(4'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/target_route_sequencer.md
Name: target_route_sequencer

Overview:
- Steps the robot through a programmable route of up to 8 polar target locations.
- Each location uses the team's 12-bit encoding: [11:7] theta in 15-degree units (5'h06 = 90 deg), [6:0] r in inches.
- Presents one target at a time to the navigation/path-planning logic. Advances when navigation reports arrival, after a settle delay. Aborts with a fault flag on timeout.
- Sits between the switch/target-selection front end and the path planner on the main FPGA.

Parameters:
- SETTLE_CYCLES, 27_000_000, dwell after each arrival before issuing the next target (1 s at 27 MHz).
- TIMEOUT_CYCLES, 1_620_000_000, maximum cycles allowed in WAIT_ARRIVE before fault (60 s at 27 MHz).
- DEFAULT_LOCATION, {5'h06,7'h18}, reset contents of every table entry (90 deg, 24 in).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  table write strobe; honoured only when busy=0.
- wr_addr  in  3  table entry to write.
- wr_data  in  12  location written to table[wr_addr].
- route_len  in  4  number of waypoints (0-8); sampled on start; values >8 are clamped to 8.
- start  in  1  single-cycle pulse; begins the route from entry 0.
- arrived  in  1  single-cycle pulse from navigation: current target reached.
- abort  in  1  level; forces return to IDLE.
- target_location  out  12  current target.
- target_valid  out  1  high while the sequencer is waiting for arrival.
- index  out  3  table entry currently issued.
- busy  out  1  high in any state other than IDLE, DONE or FAULT.
- route_done  out  1  one-cycle pulse on entering DONE.
- timeout_fault  out  1  sticky until the next start or reset.

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - All 8 table entries = DEFAULT_LOCATION.
  - target_location=DEFAULT_LOCATION.
  - target_valid=0, index=0, busy=0, route_done=0, timeout_fault=0.
  - Internal counters = 0.
  - Reset asserted mid-route takes effect immediately, and the table is reloaded with defaults.
- Table:
  - Write is synchronous.
  - A write on the same cycle as start is performed; the route reads the new value, because ISSUE occurs at least 1 cycle later.
- IDLE / DONE / FAULT:
  - On start: latch len=min(route_len,8), index=0, clear timeout_fault.
  - If len=0: go to DONE next cycle, with a route_done pulse on that cycle. Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - target_location <= table[index].
  - Clear the timer.
  - Go to WAIT_ARRIVE.
- WAIT_ARRIVE:
  - target_valid=1; the timer increments each cycle.
  - On arrived: go to SETTLE and clear the timer.
  - Else, when timer reaches TIMEOUT_CYCLES-1: go to FAULT and set timeout_fault.
  - arrived and timeout on the same cycle: arrived wins.
  - arrived pulses in any other state are ignored.
- SETTLE:
  - target_valid=0; target_location is held.
  - After SETTLE_CYCLES cycles:
    - If index==len-1: go to DONE and pulse route_done.
    - Else: index+1, go to ISSUE.
- DONE / FAULT:
  - busy=0; target_location holds the last target.
  - Only start leaves these states.
- abort:
  - In any busy state: next state is IDLE.
  - index and target_valid are cleared; target_location is held; no route_done pulse.
  - abort has priority over arrived, timeout and start.
- start while busy is ignored.
- Latency:
  - start to target_valid = 2 cycles.
  - arrived to next target_valid = SETTLE_CYCLES+2 cycles.
- Counters are 32-bit and do not wrap within a state.

Test Plan:
- Reset, then start with route_len=3 and no writes -> target_location=12'h318 (DEFAULT_LOCATION) for indices 0,1,2. route_done pulses once after the third arrival plus settle.
- Set SETTLE=4 and TIMEOUT=20. Write entry1={5'h01,7'h20} and entry2={5'h0B,7'h50}, start len=3, pulse arrived at each target -> outputs 12'h318, 12'h0A0, 12'h5D0. Arrived-to-valid gap is exactly 6 cycles.
- Start len=2 with no arrived -> FAULT after 20 WAIT_ARRIVE cycles with timeout_fault=1 and busy=0. A new start clears the fault.
- abort asserted during SETTLE, and separately on the same cycle as arrived -> IDLE next cycle, target_valid=0, no route_done.
- Start with len=0 -> route_done one cycle later, target_valid never high. Start with len=15 -> exactly 8 targets are issued.
- wr_en during WAIT_ARRIVE -> table unchanged, verified on the next route. Reset asserted mid-route -> immediate IDLE with defaults restored.
